// File: rtl/swap_stream_checker_pkg.sv
// Shared types and constants for the swap stream checker: FSM encoding,
// default lock length and the sizing rule for the match counter.
package swap_stream_checker_pkg;

  localparam int STATE_W             = 2;
  localparam int DEFAULT_LOCK_CYCLES = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // The match counter must be able to hold the value LOCK_CYCLES itself.
  function automatic int match_cnt_width(input int lock_cycles);
    if (lock_cycles < 1)
      return 1;
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/swap_stream_checker_if.sv
// Observation bus from a swap-driven source: the sample qualifier, the
// swapped register value and its combinational companion sum.
interface swap_stream_checker_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] sum_in;

  modport master (
    output en,
    output data_in,
    output sum_in
  );

  modport slave (
    input en,
    input data_in,
    input sum_in
  );

endinterface

// File: rtl/swap_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; it sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && !(&count))
      count <= count + W'(1);
  end

endmodule

// File: rtl/swap_stream_checker.sv
// Monitor for the two-register swap pattern: recovers the alternating pair,
// declares lock after a run of consistent samples, flags swap/sum violations.
module swap_stream_checker
  import swap_stream_checker_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  swap_stream_checker_if.slave src,
  output logic                 locked,
  output logic [WIDTH-1:0]     pair_a,
  output logic [WIDTH-1:0]     pair_b,
  output logic                 err_swap,
  output logic                 err_sum,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int MW = match_cnt_width(LOCK_CYCLES);

  state_t           state;
  state_t           state_next;
  logic             phase;
  logic             phase_next;
  logic             locked_next;
  logic             load_a;
  logic             load_b;
  logic             swap_bad;
  logic             sum_bad;
  logic             match_clr;
  logic             match_inc;
  logic [MW-1:0]    match_cnt;
  logic [WIDTH-1:0] expected;

  // The sum check is independent of the FSM and applies in every state.
  assign sum_bad  = src.sum_in != (src.data_in + WIDTH'(1));
  assign expected = phase ? pair_b : pair_a;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    phase_next  = phase;
    locked_next = locked;
    load_a      = 1'b0;
    load_b      = 1'b0;
    swap_bad    = 1'b0;
    match_clr   = 1'b0;
    match_inc   = 1'b0;
    if (src.en) begin
      case (state)
        IDLE: begin
          load_a     = 1'b1;
          state_next = FIRST;
        end
        FIRST: begin
          load_b     = 1'b1;
          phase_next = 1'b0;
          match_clr  = 1'b1;
          state_next = TRACK;
        end
        TRACK: begin
          if (src.data_in == expected) begin
            phase_next = ~phase;
            match_inc  = 1'b1;
            // The increment on this sample is the one that reaches LOCK_CYCLES.
            if (match_cnt == MW'(LOCK_CYCLES - 1)) begin
              locked_next = 1'b1;
              state_next  = LOCKED;
            end
          end else begin
            swap_bad   = 1'b1;
            load_a     = 1'b1;
            match_clr  = 1'b1;
            state_next = FIRST;
          end
        end
        LOCKED: begin
          if (src.data_in == expected) begin
            phase_next = ~phase;
          end else begin
            locked_next = 1'b0;
            swap_bad    = 1'b1;
            load_a      = 1'b1;
            state_next  = FIRST;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Error pulses are rebuilt every edge, so they fall on idle cycles too.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 1'b0;
      locked   <= 1'b0;
      pair_a   <= '0;
      pair_b   <= '0;
      err_swap <= 1'b0;
      err_sum  <= 1'b0;
    end else begin
      phase    <= phase_next;
      locked   <= locked_next;
      err_swap <= swap_bad;
      err_sum  <= src.en && sum_bad;
      if (load_a)
        pair_a <= src.data_in;
      if (load_b)
        pair_b <= src.data_in;
    end
  end

  sat_counter #(.W(MW)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (match_clr),
    .inc   (match_inc),
    .count (match_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (src.en && (swap_bad || sum_bad)),
    .count (err_count)
  );

endmodule

// File: tb/tb_swap_stream_checker.sv
// Self-checking bench for swap_stream_checker: directed scenarios followed by
// randomized traffic, all compared against a sample-level reference model.
module tb_swap_stream_checker;

  localparam int WIDTH = 8;
  localparam int LOCK  = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             locked;
  logic [WIDTH-1:0] pair_a;
  logic [WIDTH-1:0] pair_b;
  logic             err_swap;
  logic             err_sum;
  logic [CNTW-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: counts captured values and verified samples since capture.
  int               mCap;
  int               mRun;
  int               mCnt;
  logic [WIDTH-1:0] mA;
  logic [WIDTH-1:0] mB;
  logic             mLocked;
  logic             mSwap;
  logic             mSum;

  swap_stream_checker_if #(.WIDTH(WIDTH)) bus ();

  swap_stream_checker #(
    .WIDTH       (WIDTH),
    .LOCK_CYCLES (LOCK),
    .CNT_WIDTH   (CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (bus),
    .locked    (locked),
    .pair_a    (pair_a),
    .pair_b    (pair_b),
    .err_swap  (err_swap),
    .err_sum   (err_sum),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCap    = 0;
    mRun    = 0;
    mCnt    = 0;
    mA      = '0;
    mB      = '0;
    mLocked = 1'b0;
    mSwap   = 1'b0;
    mSum    = 1'b0;
  endtask

  task automatic modelStep(input logic e, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] es;
    logic [WIDTH-1:0] want;
    if (!e) begin
      mSwap = 1'b0;
      mSum  = 1'b0;
      return;
    end
    es    = d + 8'd1;
    mSum  = (s !== es);
    mSwap = 1'b0;
    if (mCap == 0) begin
      mA   = d;
      mCap = 1;
    end else if (mCap == 1) begin
      mB   = d;
      mCap = 2;
      mRun = 0;
    end else begin
      want = (mRun % 2 == 0) ? mA : mB;
      if (d == want) begin
        mRun++;
      end else begin
        mSwap = 1'b1;
        mA    = d;
        mCap  = 1;
        mRun  = 0;
      end
    end
    mLocked = (mCap == 2) && (mRun >= LOCK);
    if ((mSwap || mSum) && mCnt < 255)
      mCnt++;
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".locked"},    32'(locked),    32'(mLocked));
    check1({tag, ".pair_a"},    32'(pair_a),    32'(mA));
    check1({tag, ".pair_b"},    32'(pair_b),    32'(mB));
    check1({tag, ".err_swap"},  32'(err_swap),  32'(mSwap));
    check1({tag, ".err_sum"},   32'(err_sum),   32'(mSum));
    check1({tag, ".err_count"}, 32'(err_count), 32'(mCnt));
  endtask

  task automatic applyStimulus(input string tag, input logic e,
                               input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s);
    bus.en      = e;
    bus.data_in = d;
    bus.sum_in  = s;
    @(posedge clk);
    modelStep(e, d, s);
    #1;
    checkOutput(tag);
  endtask

  // Reset is driven alongside an enabled sample carrying a bad sum.
  task automatic applyReset(input string tag, input int n);
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.data_in = 8'd9;
    bus.sum_in  = 8'd0;
    repeat (n) @(posedge clk);
    modelReset();
    #1;
    checkOutput(tag);
    reset = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] s;
    logic             e;
    int               idx;

    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.data_in = '0;
    bus.sum_in  = '0;
    modelReset();
    #2;

    applyReset("reset", 2);

    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 1) ? 8'd0 : 8'd18;
      applyStimulus("nominal", 1'b1, d, d + 8'd1);
      check1("nominal.lockEdge", 32'(locked), 32'(i == 5));
    end
    check1("nominal.pairA",  32'(pair_a),    32'd18);
    check1("nominal.pairB",  32'(pair_b),    32'd0);
    check1("nominal.errCnt", 32'(err_count), 32'd0);

    applyStimulus("break", 1'b1, 8'd5, 8'd6);
    check1("break.errSwap", 32'(err_swap),  32'd1);
    check1("break.locked",  32'(locked),    32'd0);
    check1("break.errCnt",  32'(err_count), 32'd1);
    check1("break.pairA",   32'(pair_a),    32'd5);
    for (int i = 0; i < 5; i++) begin
      d = (i % 2 == 1) ? 8'd5 : 8'd0;
      applyStimulus("relock", 1'b1, d, d + 8'd1);
      check1("relock.lockEdge", 32'(locked), 32'(i == 4));
      if (i == 0)
        check1("relock.pulseDrop", 32'(err_swap), 32'd0);
    end

    applyReset("wrapReset", 1);
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 1) ? 8'd7 : 8'd255;
      s = (i % 2 == 1) ? 8'd8 : 8'd0;
      applyStimulus("wrap", 1'b1, d, s);
      check1("wrap.noSumErr", 32'(err_sum), 32'd0);
    end
    check1("wrap.locked", 32'(locked), 32'd1);
    applyStimulus("wrapBad", 1'b1, 8'd255, 8'd255);
    check1("wrapBad.errSum", 32'(err_sum),   32'd1);
    check1("wrapBad.locked", 32'(locked),    32'd1);
    check1("wrapBad.errCnt", 32'(err_count), 32'd1);
    applyStimulus("wrapOk", 1'b1, 8'd7, 8'd8);
    check1("wrapOk.errSum", 32'(err_sum), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus("gated", 1'b0, 8'($urandom), 8'($urandom));
      check1("gated.locked", 32'(locked),    32'd1);
      check1("gated.errCnt", 32'(err_count), 32'd1);
    end
    applyStimulus("ungated", 1'b1, 8'd255, 8'd0);
    check1("ungated.locked",  32'(locked),   32'd1);
    check1("ungated.errSwap", 32'(err_swap), 32'd0);

    for (int i = 0; i < 300; i++) begin
      d = (i % 2 == 1) ? 8'd255 : 8'd7;
      applyStimulus("saturate", 1'b1, d, d);
    end
    check1("saturate.errCnt", 32'(err_count), 32'd255);
    check1("saturate.locked", 32'(locked),    32'd1);
    applyStimulus("saturateHold", 1'b1, 8'd7, 8'd7);
    check1("saturateHold.errCnt", 32'(err_count), 32'd255);

    applyReset("midReset", 1);
    check1("midReset.locked", 32'(locked),    32'd0);
    check1("midReset.errCnt", 32'(err_count), 32'd0);
    check1("midReset.pairA",  32'(pair_a),    32'd0);

    for (int i = 0; i < 6; i++)
      applyStimulus("equal", 1'b1, 8'd42, 8'd43);
    check1("equal.locked", 32'(locked), 32'd1);
    check1("equal.pairA",  32'(pair_a), 32'd42);
    check1("equal.pairB",  32'(pair_b), 32'd42);

    a   = 8'($urandom);
    b   = 8'($urandom);
    idx = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyReset("randReset", 1);
        idx = 0;
      end else begin
        if ($urandom_range(0, 49) == 0) begin
          a = 8'($urandom);
          b = 8'($urandom);
        end
        e = ($urandom_range(0, 7) != 0);
        d = (idx % 2 == 0) ? a : b;
        if ($urandom_range(0, 11) == 0)
          d = 8'($urandom);
        s = d + 8'd1;
        if ($urandom_range(0, 9) == 0)
          s = 8'($urandom);
        applyStimulus("random", e, d, s);
        if (e)
          idx++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/swap_stream_checker.md
Name: swap_stream_checker

Overview:
- Receiver/checker for the two-register swap pattern. A source exchanges two WIDTH-bit registers every clock edge, so its b register alternates between two values (A, B, A, B, ...).
- The source also drives a combinational companion value, sum = b + 1.
- This block samples b and sum, recovers the value pair, declares lock after a run of consistent alternation, and flags swap and sum violations.
- It sits on the consumer side of any swap-driven datapath as a self-checking monitor; it is synthesizable and also usable in benches.

Parameters:
- WIDTH, 8, data width of the observed value and sum.
- LOCK_CYCLES, 4, consecutive matching samples required in TRACK before lock (minimum 1).
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all sampling on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample qualifier; when low, all state holds.
- data_in  input  WIDTH  observed swapped register value (b).
- sum_in  input  WIDTH  observed companion value, expected data_in+1.
- locked  output  1  registered; high while the alternation is verified.
- pair_a  output  WIDTH  registered; first-captured value of the current pair.
- pair_b  output  WIDTH  registered; second-captured value of the current pair.
- err_swap  output  1  registered one-cycle pulse on an alternation violation.
- err_sum  output  1  registered one-cycle pulse on a sum violation.
- err_count  output  CNT_WIDTH  registered saturating count of erroneous samples.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - locked, pair_a, pair_b, err_swap, err_sum, err_count, the match counter and the phase bit all go to 0.
  - Reset wins over en and over any error in the same cycle; reset mid-lock drops locked on that edge.
- Enabled sample: a rising edge with en=1 and reset=0. When en=0, registers hold, except err_swap and err_sum, which clear to 0.
- Sum rule: the expected sum is (data_in + 1) mod 2^WIDTH, so all-ones wraps to 0. Any sample with sum_in differing from this sets err_sum=1 for the next cycle. A sum error does not change FSM state.
- FSM states and transitions:
  - IDLE: on a sample, pair_a <= data_in, go to FIRST.
  - FIRST: on a sample, pair_b <= data_in, phase <= 0, match counter <= 0, go to TRACK.
  - TRACK: the expected value is pair_a when phase=0 and pair_b when phase=1.
    - Match: phase toggles and the match counter increments. When the counter reaches LOCK_CYCLES on this sample, locked <= 1 and go to LOCKED on the same edge.
    - Mismatch: err_swap pulses, pair_a <= data_in, match counter <= 0, go to FIRST.
  - LOCKED: same comparison rule as TRACK.
    - Match: phase toggles; locked stays 1.
    - Mismatch: locked <= 0, err_swap pulses, pair_a <= data_in, go to FIRST.
- Equal pair (A == B): legal. A constant stream locks.
- Lock latency:
  - Samples 1 and 2 capture the pair; samples 3 .. 2+LOCK_CYCLES are checked.
  - locked is high after the edge of sample 2+LOCK_CYCLES, i.e. sample 6 at the default LOCK_CYCLES=4.
- err_count: increments by 1 per sample having a swap error, a sum error, or both. It saturates at all-ones and does not wrap.
- Sample errors are not reported in IDLE or FIRST for err_swap; the sum check applies in every state.
- Arithmetic: all compares are unsigned WIDTH-bit; no sign extension.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE, FIRST, TRACK, LOCKED);
  - localparams for the state width and a default LOCK_CYCLES.
- One natural sub-module: sat_counter, a parameterized saturating incrementer with enable and synchronous reset. It is instantiated for err_count; the match counter may reuse it.

Test Plan:
- Nominal: reset 2 cycles, then data 18,0,18,0,... with sum 19,1,... and en=1 -> locked rises after sample 6; pair_a=18, pair_b=0; err_swap=err_sum=0; err_count=0.
- Swap break: lock on 18/0, then inject 5 in place of 18 -> err_swap pulses 1 cycle, locked=0, err_count=1, pair_a=5. Resume 0,5,0,5... -> relocks 6 samples after the break (break sample counts as sample 1).
- Sum wrap: data 255,7 alternating, sum 0,8 -> no err_sum, locks. Then sum_in=255 for data 255 -> err_sum pulses, locked stays 1, err_count=1.
- Enable gating: after locking, hold en=0 for 10 cycles while data_in is garbage -> no state change, no pulses, locked=1. Restore en with the correct phase -> stays locked.
- Saturation / reset mid-op: force 300 erroneous samples with CNT_WIDTH=8 -> err_count=255 and holds. Assert reset while locked -> next edge: all outputs 0, state IDLE.
- Equal pair: constant data 42, sum 43 -> locks after sample 6 with pair_a=pair_b=42.
